interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Prioritised, maskable, nesting interrupt controller for the single-cycle CPU.
- Captures rising edges on the 8 external interrupt lines and selects the highest-priority unmasked pending line.
- Presents the selected line's vector to the control unit and tracks in-service levels across call/return.
- The CPU's call-interrupt strobe acknowledges a request; its return strobe (end of interrupt) retires the current level.

Parameters:
N_LINES, 8, number of interrupt lines; index 0 is the highest priority.
VEC_BASE, 10'h3C0, program-counter address of the line-0 handler.
VEC_STRIDE, 8, address spacing between consecutive handler vectors.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
int_e  in  N_LINES  raw external interrupt lines, asynchronous to clk.
mask_we  in  1  write strobe for the mask register.
mask_data  in  N_LINES  new mask value; 1 enables the line.
int_ack  in  1  CPU took the interrupt (call-interrupt cycle); single-cycle pulse.
int_eoi  in  1  CPU executed return-from-interrupt; single-cycle pulse.
irq  out  1  request to the control unit.
int_vector  out  10  handler address; valid while irq=1.
pending  out  N_LINES  latched, not-yet-acknowledged edges.
in_service  out  N_LINES  levels currently being serviced.
mask  out  N_LINES  current mask register.
spurious  out  1  sticky: set by an int_ack with irq=0 or an int_eoi with in_service=0.

Behaviour:
- Reset (reset=0, asynchronous): pending=0, in_service=0, mask=0, irq=0, int_vector=0, spurious=0, FSM=IDLE, synchroniser flops=0. Reset applied mid-request discards everything; the ack of the request that was in flight is ignored, because irq=0.
- Input capture: per line, a 2-flop synchroniser plus a previous-value flop. An edge is s2 & ~s3.
  - Capture latency: a line first sampled high at clock edge k shows its pending bit after edge k+2.
  - Level-held lines generate only one edge; the line must go low and high again to re-arm.
- mask_we=1: mask <= mask_data at the next edge. Pending bits are kept whatever the mask; masking only blocks selection.
- Candidate: the lowest index i with pending[i] & mask[i], and i strictly less than the lowest set index of in_service (any i qualifies if in_service=0). Selection is combinational, with a fixed priority encoder.
- FSM, 2 states:
  - IDLE: irq=0. If a candidate exists, latch cur_idx<=i, go to REQUEST. irq rises one cycle after the candidate appears.
  - REQUEST: irq=1, int_vector = VEC_BASE + cur_idx*VEC_STRIDE, computed 10-bit with wrap-around.
    - Request is locked: cur_idx does not change while waiting, even if a higher-priority line or a mask write arrives.
    - On int_ack: pending[cur_idx]<=0, in_service[cur_idx]<=1, go to IDLE. irq falls at the next edge.
- Nesting: a higher-priority candidate may be requested while lower levels are in service. Equal or lower priority waits.
- int_eoi: clears the lowest set index of in_service. With in_service=0 it sets spurious and changes nothing else.
- int_ack in IDLE: sets spurious and changes nothing else.
- Simultaneous events:
  - New edge on cur_idx in the same cycle as int_ack: the set wins, so pending stays 1 and in_service is set.
  - int_ack and int_eoi in the same cycle: the eoi clear is evaluated on in_service before the ack's set is applied.
  - mask_we in the same cycle as candidate evaluation: the old mask is used.
- spurious clears only on reset.

Test Plan:
- Reset, mask=8'hFF, pulse int_e[3] -> pending=8'h08 two edges after first sample, irq=1 the next cycle, int_vector=10'h3D8; int_ack -> pending=0, in_service=8'h08, irq=0.
- Edges on lines 5 and 2 in the same cycle -> vector 10'h3D0 (line 2) first; ack, eoi, then line 5 vector 10'h3E8.
- Line 4 in service, edge on line 1 -> irq with vector 10'h3C8, ack gives in_service=8'h12; eoi -> 8'h10; eoi -> 8'h00. Edge on line 6 while line 4 in service -> no irq until line 4's eoi.
- mask=8'hF7, edge on line 3 -> pending[3]=1, irq=0; then write mask=8'hFF -> irq=1 with vector 10'h3D8.
- int_eoi with in_service=0 -> spurious=1, no other state change; int_ack with irq=0 -> spurious stays 1.
- irq=1, assert reset for one cycle before ack -> all outputs 0 immediately; the following ack only sets spurious.

Source files
------------

// File: rtl/interrupt_controller.sv
`timescale 1ns/1ps
// Purpose: prioritised, maskable, nesting interrupt controller (edge capture, select, vector, in-service tracking).
// Latency: raw line high at edge k -> pending after k+2 -> irq/int_vector after k+3; ack retires the request at the next edge.
// Backpressure: a presented request holds (locked index) until int_ack; new edges keep accumulating in pending meanwhile.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   int_e            raw external interrupt lines (asynchronous to clk)
//   mask_we/_data    mask register write (1 enables a line)
//   int_ack          CPU call-interrupt cycle, acknowledges the presented request
//   int_eoi          CPU return-from-interrupt, retires the highest-priority in-service level
//   irq, int_vector  request and handler address to the control unit
//   pending          latched, not-yet-acknowledged edges
//   in_service       levels currently being serviced
//   mask             current mask register
//   spurious         sticky flag for an ack without request or an eoi without service
module interrupt_controller #(
    parameter int          N_LINES    = 8,
    parameter logic [9:0]  VEC_BASE   = 10'h3C0,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LINES-1:0] int_e,
    input  logic               mask_we,
    input  logic [N_LINES-1:0] mask_data,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic               irq,
    output logic [9:0]         int_vector,
    output logic [N_LINES-1:0] pending,
    output logic [N_LINES-1:0] in_service,
    output logic [N_LINES-1:0] mask,
    output logic               spurious
);

    localparam int IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam logic [N_LINES-1:0] ONE = 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_REQUEST = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   cur_idx;

    // ------------------------------------------------------------------
    // Input capture: two synchroniser stages plus a previous-value stage.
    // ------------------------------------------------------------------
    logic [N_LINES-1:0] sync_s1;
    logic [N_LINES-1:0] sync_s2;
    logic [N_LINES-1:0] sync_s3;
    logic [N_LINES-1:0] edge_det;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
        end else begin
            sync_s1 <= int_e;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    // A level held high produces exactly one edge; it must drop to re-arm.
    assign edge_det = sync_s2 & ~sync_s3;

    // ------------------------------------------------------------------
    // Candidate selection.
    // ------------------------------------------------------------------
    logic [N_LINES-1:0] isr_lowest;   // one-hot of highest-priority level in service
    logic [N_LINES-1:0] prio_allow;   // lines strictly above that level
    logic [N_LINES-1:0] eligible;
    logic               cand_vld;
    logic [IDX_W-1:0]   cand_idx;

    // x & -x isolates the lowest set bit; subtracting one yields every
    // index below it, i.e. the strictly higher priorities.
    assign isr_lowest = in_service & (~in_service + ONE);
    assign prio_allow = (in_service == '0) ? '1 : (isr_lowest - ONE);
    assign eligible   = pending & mask & prio_allow;

    // Fixed priority encoder: index 0 wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM: state register / next-state / outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cand_vld) begin
                    state_nxt = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (int_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        irq        = 1'b0;
        int_vector = '0;
        if (state == ST_REQUEST) begin
            irq        = 1'b1;
            // 10-bit arithmetic, wraps by construction.
            int_vector = VEC_BASE + (10'(cur_idx) * 10'(VEC_STRIDE));
        end
    end

    // The presented index is latched only on entry to REQUEST, so later
    // higher-priority edges or mask writes cannot retarget a request the
    // CPU may already be acting on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_idx <= '0;
        end else if (state == ST_IDLE && cand_vld) begin
            cur_idx <= cand_idx;
        end
    end

    // ------------------------------------------------------------------
    // Pending / in-service / mask / spurious.
    // ------------------------------------------------------------------
    logic               ack_take;
    logic [N_LINES-1:0] ack_onehot;
    logic [N_LINES-1:0] eoi_clr;
    logic               spur_set;

    assign ack_take   = int_ack && (state == ST_REQUEST);
    assign ack_onehot = ack_take ? (ONE << cur_idx) : '0;
    // eoi retires from the pre-ack in_service, so an ack+eoi in the same
    // cycle never retires the level being entered.
    assign eoi_clr    = int_eoi ? isr_lowest : '0;
    assign spur_set   = (int_ack && (state == ST_IDLE)) ||
                        (int_eoi && (in_service == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            in_service <= '0;
            mask       <= '0;
            spurious   <= 1'b0;
        end else begin
            // A fresh edge on the acknowledged line wins over the clear.
            pending    <= (pending & ~ack_onehot) | edge_det;
            in_service <= (in_service & ~eoi_clr) | ack_onehot;
            if (mask_we) begin
                mask <= mask_data;
            end
            if (spur_set) begin
                spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
`timescale 1ns/1ps
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] int_e;
    logic       mask_we;
    logic [7:0] mask_data;
    logic       int_ack;
    logic       int_eoi;
    logic       irq;
    logic [9:0] int_vector;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic [7:0] mask;
    logic       spurious;

    int n_assert = 0;
    int n_fail   = 0;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .int_e      (int_e),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
        .irq        (irq),
        .int_vector (int_vector),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask),
        .spurious   (spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: pending/in-service sets, a request flag with the
    // line it names, and the history of raw samples taken at each edge.
    bit [7:0] m_pend, m_isr, m_mask;
    bit       m_req, m_spur;
    int       m_line;
    bit [7:0] samp0, samp1, samp2;   // int_e at last edge, one before, two before

    function automatic void model_reset();
        m_pend = '0; m_isr = '0; m_mask = '0;
        m_req = 1'b0; m_spur = 1'b0; m_line = 0;
        samp0 = '0; samp1 = '0; samp2 = '0;
    endfunction

    function automatic int lowest_set(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic void model_step();
        int       cand = -1;
        int       top_isr = lowest_set(m_isr);
        bit [7:0] n_pend = m_pend;
        bit [7:0] n_isr  = m_isr;
        bit       n_req  = m_req;
        int       n_line = m_line;
        bit       n_spur = m_spur;
        for (int i = 0; i < 8; i++)
            if (cand < 0 && m_pend[i] && m_mask[i] && i < top_isr) cand = i;
        if (int_eoi) begin
            if (m_isr == 0) n_spur = 1'b1;
            else            n_isr[top_isr] = 1'b0;
        end
        if (!m_req) begin
            if (int_ack) n_spur = 1'b1;
            if (cand >= 0) begin n_req = 1'b1; n_line = cand; end
        end else if (int_ack) begin
            n_pend[m_line] = 1'b0;
            n_isr[m_line]  = 1'b1;
            n_req          = 1'b0;
        end
        // Edge seen by the line-capture logic this cycle: high one sample ago, low two ago.
        n_pend = n_pend | (samp1 & ~samp2);
        if (mask_we) m_mask = mask_data;
        m_pend = n_pend; m_isr = n_isr; m_req = n_req; m_line = n_line; m_spur = n_spur;
        samp2 = samp1; samp1 = samp0; samp0 = int_e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [9:0] ev;
        ev = m_req ? 10'((960 + 8 * m_line) % 1024) : 10'h000;
        chk("pending",    32'(pending),    32'(m_pend));
        chk("in_service", 32'(in_service), 32'(m_isr));
        chk("mask",       32'(mask),       32'(m_mask));
        chk("irq",        32'(irq),        32'(m_req));
        chk("int_vector", 32'(int_vector), 32'(ev));
        chk("spurious",   32'(spurious),   32'(m_spur));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        int_ack = 1'b0;
        int_eoi = 1'b0;
        mask_we = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we = 1'b1; mask_data = v; tick();
    endtask

    // Raise lines for one sample, drop them, and let capture complete.
    task automatic pulse(input logic [7:0] lines);
        int_e = lines; tick();
        int_e = 8'h00; tick();
        tick();
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 20 && irq !== 1'b1; i++) tick();
        chk(tag, 32'(irq), 32'd1);
    endtask

    task automatic ack();  int_ack = 1'b1; tick(); endtask
    task automatic eoi();  int_eoi = 1'b1; tick(); endtask

    initial begin
        reset = 1'b0; int_e = '0; mask_we = 1'b0; mask_data = '0;
        int_ack = 1'b0; int_eoi = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all();
        reset = 1'b1;

        // Single line, capture latency and vector.
        write_mask(8'hFF);
        int_e = 8'h08; tick();           // first sampled high here (edge k)
        int_e = 8'h00; tick();           // k+1
        chk("pend_not_yet", 32'(pending), 32'h00);
        tick();                          // k+2
        chk("pend_l3", 32'(pending), 32'h08);
        chk("irq_not_yet", 32'(irq), 32'd0);
        tick();                          // k+3
        chk("irq_l3", 32'(irq), 32'd1);
        chk("vec_l3", 32'(int_vector), 32'h3D8);
        ack();
        chk("isr_l3", 32'(in_service), 32'h08);
        chk("irq_after_ack", 32'(irq), 32'd0);
        eoi();

        // Two simultaneous edges: line 2 first, line 5 after its eoi.
        pulse(8'h24);
        wait_irq("irq_l2");
        chk("vec_l2", 32'(int_vector), 32'h3D0);
        ack();
        eoi();
        wait_irq("irq_l5");
        chk("vec_l5", 32'(int_vector), 32'h3E8);
        ack();
        eoi();

        // Nesting.
        pulse(8'h10);
        wait_irq("irq_l4");
        ack();
        pulse(8'h02);
        wait_irq("irq_l1");
        chk("vec_l1", 32'(int_vector), 32'h3C8);
        ack();
        chk("isr_nest", 32'(in_service), 32'h12);
        eoi();
        chk("isr_eoi1", 32'(in_service), 32'h10);
        eoi();
        chk("isr_eoi2", 32'(in_service), 32'h00);
        pulse(8'h10);
        wait_irq("irq_l4b");
        ack();
        pulse(8'h40);
        for (int i = 0; i < 5; i++) tick();
        chk("l6_blocked", 32'(irq), 32'd0);
        eoi();
        wait_irq("irq_l6");
        chk("vec_l6", 32'(int_vector), 32'h3F0);
        ack();
        eoi();

        // Masked line stays pending, fires when unmasked.
        write_mask(8'hF7);
        pulse(8'h08);
        tick(); tick();
        chk("masked_pend", 32'(pending[3]), 32'd1);
        chk("masked_irq", 32'(irq), 32'd0);
        write_mask(8'hFF);
        wait_irq("irq_unmask");
        chk("vec_unmask", 32'(int_vector), 32'h3D8);
        ack();
        eoi();

        // Spurious eoi, then spurious ack.
        eoi();
        chk("spur_eoi", 32'(spurious), 32'd1);
        ack();
        chk("spur_ack", 32'(spurious), 32'd1);

        // Reset while a request is presented.
        pulse(8'h01);
        wait_irq("irq_l0");
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        ack();
        chk("rst_ack_spur", 32'(spurious), 32'd1);
        chk("rst_ack_isr", 32'(in_service), 32'h00);

        // Randomised traffic against the model.
        write_mask(8'hFF);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) int_e = int_e ^ 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                mask_we = 1'b1;
                mask_data = 8'($urandom) | 8'($urandom);
            end
            if (m_req && $urandom_range(0, 2) == 0) int_ack = 1'b1;
            else if ($urandom_range(0, 60) == 0) int_ack = 1'b1;
            if (m_isr != 0 && $urandom_range(0, 5) == 0) int_eoi = 1'b1;
            else if ($urandom_range(0, 80) == 0) int_eoi = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
